// File: rtl/bin_to_bcd_disp.sv
// ============================================================================
// bin_to_bcd_disp : 27-bit binary to 8-digit BCD (double-dabble) for 7-seg scan
// Optional macro: BCD_LEADING_ZERO_BLANK_EN (blank leading-zero digits)
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_disp (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] in_value,
  output logic [31:0] digits,
  output logic [7:0]  anodes_mask,
  output logic        out_valid,
  output logic        overflow
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  SHIFT     = 2'd1;
  localparam logic [1:0]  DONE      = 2'd2;
  localparam logic [26:0] MAX_VALUE = 27'd99_999_999;
  localparam logic [4:0]  LAST_STEP = 5'd26;
  localparam logic [31:0] OVF_DIGITS = 32'hEEEE_EEEE;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [7:0]  MASK_RST  = 8'h01;
`else
  localparam logic [7:0]  MASK_RST  = 8'hFF;
`endif

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        load_en;
  logic        shift_en;
  logic        done_en;
  logic [26:0] bin_q;
  logic [31:0] bcd_q;
  logic [31:0] bcd_adj;
  logic [4:0]  bit_cnt;
  logic        ovf_q;
  logic [7:0]  blank_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = SHIFT;
      SHIFT:   if (bit_cnt == LAST_STEP) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    load_en  = (state == IDLE) && in_valid;
    shift_en = (state == SHIFT);
    done_en  = (state == DONE);
  end

  // Add-3 correction stays inside each nibble; no carry into the next digit.
  for (genvar i = 0; i < 8; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                         : bcd_q[4*i +: 4];
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign blank_mask[0] = 1'b1;
  for (genvar i = 1; i < 8; i++) begin : g_blank
    assign blank_mask[i] = |bcd_q[31:4*i];
  end
`else
  assign blank_mask = 8'hFF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      ovf_q   <= 1'b0;
    end else if (load_en) begin
      bin_q   <= in_value;
      bcd_q   <= '0;
      bit_cnt <= '0;
      ovf_q   <= (in_value > MAX_VALUE);
    end else if (shift_en) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      bit_cnt        <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '0;
      anodes_mask <= MASK_RST;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= done_en;
      if (done_en) begin
        digits      <= ovf_q ? OVF_DIGITS : bcd_q;
        anodes_mask <= ovf_q ? 8'hFF : blank_mask;
        overflow    <= ovf_q;
      end
    end
  end

endmodule

`default_nettype wire
